hazard_controller: RTL and testbench
====================================

# hazard_controller

Pipeline sequencing unit for the five-stage RISC-V core. Generates stall and flush enables for the IF/ID, ID/EX, EX/MEM and MEM/WB registers from three causes: load-use hazards, taken control transfers resolved in EX, and multi-cycle data-memory accesses in MEM. Runs a small FSM that freezes the pipeline while the data memory withholds ready, detects a hung access via a timeout, and keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- TIMEOUT, 64: max MEM_WAIT cycles before declaring a hung access (≥2).
- CNT_W, 32: width of stall-cycle counter.

Ports:
- clk  input  1  pipeline clock; all state updates on the falling edge, same edge as the pipeline registers.
- rst_n  input  1  synchronous, active-low reset.
- Rs1D_i  input  ADDR_BUS  source register 1 of instruction in ID.
- Rs2D_i  input  ADDR_BUS  source register 2 of instruction in ID.
- RdE_i  input  ADDR_BUS  destination of instruction in EX.
- ResultSrcE_i  input  1  instruction in EX is a load.
- PCSrcE_i  input  1  taken branch/jump resolved in EX.
- MemReqM_i  input  1  instruction in MEM accesses data memory.
- MemReadyM_i  input  1  data memory completes access this cycle.
- StallF_o, StallD_o, StallE_o, StallM_o  output  1 each  hold PC / IF-ID / ID-EX / EX-MEM.
- FlushD_o, FlushE_o, FlushW_o  output  1 each  insert bubble into IF-ID / ID-EX / MEM-WB.
- MemBusy_o  output  1  FSM in MEM_WAIT.
- Error_o  output  1  sticky hung-access flag.
- StallCount_o  output  CNT_W  cycles with StallF_o asserted.

## Operation
- FSM states (hazard_state): RUN, MEM_WAIT, HUNG.
- Stall/flush outputs are combinational from current state and inputs, valid before the next falling edge.
- Load-use (RUN only): ResultSrcE_i && RdE_i≠0 && (RdE_i==Rs1D_i || RdE_i==Rs2D_i) → StallF, StallD, FlushE.
- Control transfer (RUN only): PCSrcE_i → FlushD, FlushE; overrides load-use (no stall that cycle).
- Memory wait: MemReqM_i && !MemReadyM_i in RUN or MEM_WAIT → StallF, StallD, StallE, StallM, FlushW; overrides load-use and control transfer (branch in EX stays frozen and is taken on release).
- Transitions: RUN→MEM_WAIT on MemReqM_i && !MemReadyM_i; MEM_WAIT→RUN on MemReadyM_i (stalls deasserted that same cycle); MEM_WAIT→HUNG when wait counter reaches TIMEOUT−1 without ready; HUNG is absorbing until reset.
- MemReqM_i dropping while in MEM_WAIT is treated as ready (→RUN).
- HUNG: all four stalls and FlushW asserted, Error_o=1, MemBusy_o=0.
- Wait counter: cleared on entry to MEM_WAIT, increments each MEM_WAIT cycle.
- StallCount_o increments on every falling edge with StallF_o=1; saturates at all-ones.

## Timing
- Reset (rst_n=0 at falling edge): state RUN, wait counter 0, StallCount_o 0, Error_o 0. While rst_n=0, outputs forced: stalls 0, FlushD/FlushE/FlushW 1, MemBusy_o 0.
- Reset mid-MEM_WAIT or in HUNG: RUN after that edge, no residual stall.
- Ready in the same cycle as request: zero stall cycles.
- Access with ready after N cycles (N<TIMEOUT): exactly N stall cycles, MemBusy_o high for N−1 of them (from the second).
- Load-use costs exactly one bubble; the next cycle the load is in MEM and no longer matches.

## Structure
- types_pkg: add hazard_state enum (RUN, MEM_WAIT, HUNG); reuse ADDR_BUS.
- One sub-module: hazard_wait_timer (clear/enable/expire, parameter TIMEOUT) instantiated for the MEM_WAIT timeout; StallCount is inline.

## Test plan
- ResultSrcE=1, RdE=5, Rs1D=5, PCSrcE=0 → StallF=StallD=FlushE=1 for one cycle, StallCount 0→1.
- Same as above with RdE=0 → no stall; with PCSrcE=1 → FlushD=FlushE=1, StallF=0.
- MemReqM=1, ready after 3 cycles, PCSrcE=1 throughout → all stalls+FlushW for 3 cycles, then FlushD/FlushE on release cycle; StallCount=3.
- MemReqM=1, ready never, TIMEOUT=8 → HUNG after 8 stall cycles, Error_o=1 held; rst_n=0 one edge → Error_o=0, state RUN.
- Preload StallCount=all-ones−1, two stall cycles → saturates at all-ones.

Source files
------------

// File: rtl/types_pkg.sv
// Shared types for the five-stage core: register-address width and the
// hazard controller's sequencing states.
package types_pkg;
    localparam int ADDR_BUS = 5;

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        HUNG
    } hazard_state;
endpackage

// File: rtl/hazard_wait_timer.sv
// Counts MEM_WAIT cycles and flags expiry on the cycle whose edge would bring
// the count to TIMEOUT-1, i.e. TIMEOUT stall cycles after the request began.
module hazard_wait_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] count;

    always_ff @(negedge clk) begin
        if (!rst_n || clear)
            count <= '0;
        else if (enable && count != CW'(TIMEOUT - 1))
            count <= count + 1'b1;
    end

    assign expire = enable && (count == CW'(TIMEOUT - 2));
endmodule

// File: rtl/hazard_controller.sv
// Stall/flush sequencing for the five-stage pipeline: load-use bubbles,
// EX-resolved control transfers, and freezing on slow data-memory accesses.
module hazard_controller
    import types_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_BUS-1:0] Rs1D_i,
    input  logic [ADDR_BUS-1:0] Rs2D_i,
    input  logic [ADDR_BUS-1:0] RdE_i,
    input  logic                ResultSrcE_i,
    input  logic                PCSrcE_i,
    input  logic                MemReqM_i,
    input  logic                MemReadyM_i,
    output logic                StallF_o,
    output logic                StallD_o,
    output logic                StallE_o,
    output logic                StallM_o,
    output logic                FlushD_o,
    output logic                FlushE_o,
    output logic                FlushW_o,
    output logic                MemBusy_o,
    output logic                Error_o,
    output logic [CNT_W-1:0]    StallCount_o
);
    hazard_state state, nextState;
    logic        loadUse, memWait, timerExpire;

    assign loadUse = ResultSrcE_i && (RdE_i != '0) &&
                     ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));
    assign memWait = (state != HUNG) && MemReqM_i && !MemReadyM_i;

    hazard_wait_timer #(.TIMEOUT(TIMEOUT)) uWaitTimer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state == RUN),
        .enable (state == MEM_WAIT),
        .expire (timerExpire)
    );

    always_ff @(negedge clk) begin
        if (!rst_n)
            state <= RUN;
        else
            state <= nextState;
    end

    // A dropped request while waiting releases the pipeline just like ready.
    always_comb begin
        nextState = state;
        case (state)
            RUN:      if (memWait) nextState = MEM_WAIT;
            MEM_WAIT: begin
                if (!MemReqM_i || MemReadyM_i) nextState = RUN;
                else if (timerExpire)          nextState = HUNG;
            end
            HUNG:     nextState = HUNG;
            default:  nextState = RUN;
        endcase
    end

    // Memory freeze beats control transfer, which beats load-use; the branch
    // held in EX is then taken on the release cycle.
    always_comb begin
        StallF_o  = 1'b0;
        StallD_o  = 1'b0;
        StallE_o  = 1'b0;
        StallM_o  = 1'b0;
        FlushD_o  = 1'b0;
        FlushE_o  = 1'b0;
        FlushW_o  = 1'b0;
        MemBusy_o = 1'b0;
        if (!rst_n) begin
            FlushD_o = 1'b1;
            FlushE_o = 1'b1;
            FlushW_o = 1'b1;
        end else begin
            MemBusy_o = (state == MEM_WAIT);
            if (state == HUNG || memWait) begin
                StallF_o = 1'b1;
                StallD_o = 1'b1;
                StallE_o = 1'b1;
                StallM_o = 1'b1;
                FlushW_o = 1'b1;
            end else if (PCSrcE_i) begin
                FlushD_o = 1'b1;
                FlushE_o = 1'b1;
            end else if (loadUse) begin
                StallF_o = 1'b1;
                StallD_o = 1'b1;
                FlushE_o = 1'b1;
            end
        end
    end

    assign Error_o = (state == HUNG);

    always_ff @(negedge clk) begin
        if (!rst_n)
            StallCount_o <= '0;
        else if (StallF_o && StallCount_o != '1)
            StallCount_o <= StallCount_o + 1'b1;
    end
endmodule

// File: tb/tb_hazard_controller.sv
// Directed and randomized checks of hazard_controller against a cycle-level
// behavioural model built from the stall/flush rules.
module tb_hazard_controller;
    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 6;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] Rs1D_i, Rs2D_i, RdE_i;
    logic ResultSrcE_i, PCSrcE_i, MemReqM_i, MemReadyM_i;
    logic StallF_o, StallD_o, StallE_o, StallM_o;
    logic FlushD_o, FlushE_o, FlushW_o, MemBusy_o, Error_o;
    logic [CNT_W-1:0] StallCount_o;

    int nAsserts = 0;
    int nFail    = 0;

    // model state: consecutive memory-wait cycles, hung flag, stall counter
    int mWait = 0;
    bit mHung = 0;
    int mCnt  = 0;

    hazard_controller #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D_i(Rs1D_i), .Rs2D_i(Rs2D_i), .RdE_i(RdE_i),
        .ResultSrcE_i(ResultSrcE_i), .PCSrcE_i(PCSrcE_i),
        .MemReqM_i(MemReqM_i), .MemReadyM_i(MemReadyM_i),
        .StallF_o(StallF_o), .StallD_o(StallD_o), .StallE_o(StallE_o), .StallM_o(StallM_o),
        .FlushD_o(FlushD_o), .FlushE_o(FlushE_o), .FlushW_o(FlushW_o),
        .MemBusy_o(MemBusy_o), .Error_o(Error_o), .StallCount_o(StallCount_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAsserts++;
        assert (obs === exp)
        else begin
            nFail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One pipeline cycle: drive at posedge, check combinational outputs,
    // then advance the model at the falling edge.
    task automatic step(input bit rn, input bit ld, input logic [4:0] rd,
                        input logic [4:0] r1, input logic [4:0] r2,
                        input bit pc, input bit req, input bit rdy);
        bit eSF, eSD, eSE, eSM, eFD, eFE, eFW, eBusy, lu, mw;
        @(posedge clk);
        #1;
        rst_n = rn; ResultSrcE_i = ld; RdE_i = rd; Rs1D_i = r1; Rs2D_i = r2;
        PCSrcE_i = pc; MemReqM_i = req; MemReadyM_i = rdy;
        #1;
        lu = ld && rd != 0 && (rd == r1 || rd == r2);
        mw = !mHung && req && !rdy;
        {eSF, eSD, eSE, eSM, eFD, eFE, eFW, eBusy} = '0;
        if (!rn) begin
            {eFD, eFE, eFW} = 3'b111;
        end else begin
            eBusy = (mWait > 0) && !mHung;
            if (mHung || mw) {eSF, eSD, eSE, eSM, eFW} = 5'b11111;
            else if (pc)     {eFD, eFE} = 2'b11;
            else if (lu)     {eSF, eSD, eFE} = 3'b111;
        end
        chk("StallF", StallF_o, eSF);
        chk("StallD", StallD_o, eSD);
        chk("StallE", StallE_o, eSE);
        chk("StallM", StallM_o, eSM);
        chk("FlushD", FlushD_o, eFD);
        chk("FlushE", FlushE_o, eFE);
        chk("FlushW", FlushW_o, eFW);
        chk("MemBusy", MemBusy_o, eBusy);
        chk("Error", Error_o, mHung);
        chk("StallCount", StallCount_o, mCnt);
        @(negedge clk);
        if (!rn) begin
            mWait = 0; mHung = 0; mCnt = 0;
        end else begin
            if (eSF && mCnt != CMAX) mCnt++;
            if (!mHung) begin
                if (mw) begin
                    mWait++;
                    if (mWait == TIMEOUT) mHung = 1;
                end else begin
                    mWait = 0;
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; ResultSrcE_i = 0; RdE_i = 0; Rs1D_i = 0; Rs2D_i = 0;
        PCSrcE_i = 0; MemReqM_i = 0; MemReadyM_i = 0;
        // reset
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 5, 5, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        // load-use bubble, then the load has moved on
        step(1, 1, 5, 5, 0, 0, 0, 0);
        step(1, 0, 7, 5, 0, 0, 0, 0);
        step(1, 1, 5, 0, 5, 0, 0, 0);
        // x0 destination never stalls; branch overrides load-use
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 5, 5, 0, 1, 0, 0);
        // three-cycle access with a branch frozen in EX
        step(1, 0, 0, 0, 0, 1, 1, 0);
        step(1, 0, 0, 0, 0, 1, 1, 0);
        step(1, 0, 0, 0, 0, 1, 1, 0);
        step(1, 0, 0, 0, 0, 1, 1, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        // same-cycle ready, then dropped request while waiting
        step(1, 0, 0, 0, 0, 0, 1, 1);
        step(1, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        // TIMEOUT-1 cycle access completes without hanging
        for (int i = 0; i < TIMEOUT - 1; i++) step(1, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 1, 1);
        // hung access, ready arriving late is ignored, reset recovers
        for (int i = 0; i < TIMEOUT + 3; i++) step(1, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        // reset in the middle of a wait
        step(1, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        // drive the stall counter into saturation
        for (int i = 0; i < CMAX + 4; i++) step(1, 1, 3, 3, 3, 0, 0, 0);
        // randomized traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 59) != 0),
                 $urandom_range(0, 1),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 4) == 0));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end
endmodule
